// File: rtl/act_vote_collector.sv
// Counts per-neuron firings over a sampling window, then scans for the argmax neuron
// and offers it on a valid/ready port. Define ACT_VOTE_INREG_EN to register act_in/ena first.
module act_vote_collector #(
    parameter int N       = 8,
    parameter int IDX_W   = 3,
    parameter int WINDOW  = 16,
    parameter int COUNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [N-1:0]       act_in,
    output logic               busy,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [IDX_W-1:0]   win_idx,
    output logic [COUNT_W-1:0] win_count,
    output logic               win_tie
);

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

    localparam logic [COUNT_W-1:0] MAX_CNT     = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] LAST_SAMPLE = COUNT_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N - 1);

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   cnt_q [N];
    logic [COUNT_W-1:0]   cnt_d [N];
    logic [COUNT_W-1:0]   samp_q, samp_d;
    logic [IDX_W-1:0]     scan_q, scan_d;
    logic [COUNT_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]     bidx_q, bidx_d;
    logic                 btie_q, btie_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic [IDX_W-1:0]     widx_q, widx_d;
    logic [COUNT_W-1:0]   wcnt_q, wcnt_d;
    logic                 wtie_q, wtie_d;

    logic [N-1:0]         smp_act;
    logic                 smp_ena;

`ifdef ACT_VOTE_INREG_EN
    logic [N-1:0] act_q;
    logic         ena_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= '0;
            ena_q <= 1'b0;
        end else begin
            act_q <= act_in;
            ena_q <= ena;
        end
    end

    assign smp_act = act_q;
    assign smp_ena = ena_q;
`else
    assign smp_act = act_in;
    assign smp_ena = ena;
`endif

    // Running argmax candidate for the neuron currently under the scan pointer.
    logic [COUNT_W-1:0] cur_cnt, cand_best;
    logic [IDX_W-1:0]   cand_idx;
    logic               cand_tie;

    always_comb begin
        cur_cnt   = cnt_q[scan_q];
        cand_best = best_q;
        cand_idx  = bidx_q;
        cand_tie  = btie_q;
        if (scan_q == '0) begin
            cand_best = cur_cnt;
            cand_idx  = '0;
            cand_tie  = 1'b0;
        end else if (cur_cnt > best_q) begin
            cand_best = cur_cnt;
            cand_idx  = scan_q;
            cand_tie  = 1'b0;
        end else if (cur_cnt == best_q) begin
            cand_tie  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        scan_d  = scan_q;
        best_d  = best_q;
        bidx_d  = bidx_q;
        btie_d  = btie_q;
        valid_d = valid_q;
        widx_d  = widx_q;
        wcnt_d  = wcnt_q;
        wtie_d  = wtie_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    samp_d  = '0;
                    for (int i = 0; i < N; i++) cnt_d[i] = '0;
                end
            end
            ACCUM: begin
                if (smp_ena) begin
                    for (int i = 0; i < N; i++) begin
                        if (smp_act[i] && (cnt_q[i] != MAX_CNT))
                            cnt_d[i] = cnt_q[i] + COUNT_W'(1);
                    end
                    samp_d = samp_q + COUNT_W'(1);
                    if (samp_q == LAST_SAMPLE) begin
                        state_d = SCAN;
                        scan_d  = '0;
                    end
                end
            end
            SCAN: begin
                best_d = cand_best;
                bidx_d = cand_idx;
                btie_d = cand_tie;
                scan_d = scan_q + IDX_W'(1);
                if (scan_q == LAST_IDX) begin
                    state_d = DONE;
                    scan_d  = '0;
                    widx_d  = cand_idx;
                    wcnt_d  = cand_best;
                    wtie_d  = cand_tie;
                end
            end
            DONE: begin
                // Valid rises one edge after the result is loaded and drops on the transfer edge.
                if (valid_q && win_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ACCUM) || (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            samp_q  <= '0;
            scan_q  <= '0;
            best_q  <= '0;
            bidx_q  <= '0;
            btie_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            widx_q  <= '0;
            wcnt_q  <= '0;
            wtie_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            samp_q  <= samp_d;
            scan_q  <= scan_d;
            best_q  <= best_d;
            bidx_q  <= bidx_d;
            btie_q  <= btie_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            widx_q  <= widx_d;
            wcnt_q  <= wcnt_d;
            wtie_q  <= wtie_d;
        end
    end

    assign busy      = busy_q;
    assign win_valid = valid_q;
    assign win_idx   = widx_q;
    assign win_count = wcnt_q;
    assign win_tie   = wtie_q;

endmodule

// File: doc/act_vote_collector.md
Name: act_vote_collector

Overview:
- Sits directly downstream of the 8-neuron perceptron/activation layer.
- Consumes the 8-bit activation vector (one bit per neuron) and counts how many times each neuron fires over a fixed sampling window.
- Scans the counts to find the winning neuron (argmax) and presents its index and count through a valid/ready handshake.
- Output drives the display/readout stage.

Parameters:
- N, 8: number of neurons (activation bits).
- IDX_W, 3: winner index width; must satisfy 2^IDX_W >= N.
- WINDOW, 16: number of samples per classification; legal range 1 to 2^COUNT_W-1.
- COUNT_W, 5: per-neuron counter width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  sample enable; act_in is counted only on cycles where ena=1.
- start  input  1  begin a classification; accepted only in IDLE.
- act_in  input  N  activation vector, bit i = neuron i fired.
- busy  output  1  high in ACCUM or SCAN.
- win_valid  output  1  result available.
- win_ready  input  1  consumer accepts the result.
- win_idx  output  IDX_W  index of the winning neuron.
- win_count  output  COUNT_W  fire count of the winning neuron.
- win_tie  output  1  another neuron has the same maximum count.

Behaviour:
- Reset (rst_n=0, asynchronous, effective at any time including mid-window or mid-scan):
  - FSM goes to IDLE; all counters, sample count and scan registers clear to 0.
  - busy=0, win_valid=0, win_idx=0, win_count=0, win_tie=0.
- State machine: IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - start=1 → ACCUM; per-neuron counters and sample counter clear at the same edge.
  - start is ignored in every other state.
- ACCUM:
  - On each edge with ena=1: for each i, cnt[i] increments if act_in[i]=1; sample counter increments.
  - Counters saturate at 2^COUNT_W-1 and never wrap.
  - ena=0 freezes counters and the sample counter; the window pauses.
  - At the edge that takes the WINDOW-th sample → SCAN.
- SCAN: one neuron per cycle, i = 0..N-1, N cycles total.
  - i=0: best=cnt[0], idx=0, tie=0.
  - i>0, cnt[i] > best: best=cnt[i], idx=i, tie=0.
  - i>0, cnt[i] == best: tie=1; idx is unchanged, so the lower index wins ties.
  - After i=N-1 → DONE, with win_idx, win_count and win_tie loaded.
  - ena has no effect in SCAN.
- DONE:
  - win_valid=1; win_idx, win_count and win_tie are held stable until the handshake.
  - win_valid=1 and win_ready=1 at an edge → IDLE; win_valid=0 from the next cycle; data outputs keep their last values.
  - win_ready while win_valid=0 is ignored.
  - start while in DONE is ignored; a new start is accepted only once back in IDLE.
- Latency with ena held 1: win_valid rises on the edge 1+WINDOW+N edges after the edge that captured start.
  - Defaults: 25 edges.
- busy is a registered decode of the state (ACCUM or SCAN).
- All-zero counts give win_idx=0, win_count=0, win_tie=1 (when N>1).

Optional Feature:
- Macro: ACT_VOTE_INREG_EN.
- Defined:
  - act_in and ena pass through one register stage (act_q, ena_q).
  - ACCUM counts act_q, gated by ena_q.
  - start is not delayed, so each counted sample is the act_in value from one cycle earlier.
  - Reset clears act_q and ena_q to 0.
  - Edge count from start to win_valid is unchanged with constant ena.
- Undefined: act_in and ena are used directly; no extra registers.

Test Plan:
- Reset values: assert rst_n=0 mid-ACCUM after 5 samples → busy=0, win_valid=0, outputs 0; after release with start, cnt restarts from 0.
- Single winner: defaults, ena=1, act_in=8'b0000_1000 for 16 cycles → win_valid after 25 edges; win_idx=3, win_count=16, win_tie=0.
- Tie: act_in alternates 8'h05 / 8'h04 over 16 samples → cnt0=8, cnt2=16; then 8'h24 constant (bits 2 and 5) → win_idx=2, win_count=16, win_tie=1.
- ena gating: act_in=8'h80, ena low for 10 cycles inside the window → win_valid delayed by 10 edges; win_idx=7, win_count=16.
- Backpressure: win_ready=0 for 7 cycles after win_valid, start pulsed during DONE → outputs stable; start ignored; transfer on ready; IDLE next.
- Saturation: COUNT_W=3, WINDOW=7 → count stops at 7; WINDOW=7 with act_in=8'hFF → all counts 7; win_idx=0, win_tie=1.
